// File: rtl/fmt_pkg.sv
// Shared encodings for the streaming number formatter: radix codes, flag bit
// positions, the control state enum and the ASCII characters it emits.
package fmt_pkg;

  localparam logic [1:0] RADIX_BIN = 2'b00;
  localparam logic [1:0] RADIX_OCT = 2'b01;
  localparam logic [1:0] RADIX_DEC = 2'b10;
  localparam logic [1:0] RADIX_HEX = 2'b11;

  localparam int FLAG_LEFT   = 0;
  localparam int FLAG_ZERO   = 1;
  localparam int FLAG_SIGNED = 2;
  localparam int FLAG_PLUS   = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_SCAN, S_PRE_PAD, S_SIGN, S_DIGITS, S_POST_PAD
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_LC_A  = 8'h61;
  localparam logic [7:0] ASCII_UC_A  = 8'h41;

  // Decimal digits needed for 2^w-1 (30103/100000 approximates log10(2)).
  function automatic int dec_digits(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Iterative double-dabble binary-to-BCD converter: start_i loads and performs
// the first shift, done_o pulses once all DATA_W shifts are complete.
module bin2bcd_dd #(
  parameter int DATA_W = 32,
  parameter int BCD_W  = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] bin_i,
  output logic              done_o,
  output logic [BCD_W-1:0]  bcd_o
);
  logic [DATA_W-1:0] bin_q, bin_d, src_bin;
  logic [BCD_W-1:0]  bcd_q, bcd_d, src_bcd, adj;
  logic [5:0]        cnt_q;
  logic              busy_q, done_q;

  assign src_bcd = start_i ? '0 : bcd_q;
  assign src_bin = start_i ? bin_i : bin_q;

  for (genvar gi = 0; gi < BCD_W / 4; gi++) begin : g_adj
    assign adj[4*gi +: 4] = (src_bcd[4*gi +: 4] >= 4'd5) ? src_bcd[4*gi +: 4] + 4'd3
                                                         : src_bcd[4*gi +: 4];
  end

  assign {bcd_d, bin_d} = {adj[BCD_W-2:0], src_bin, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        busy_q <= 1'b1;
        cnt_q  <= 6'(DATA_W - 1);
      end else if (busy_q) begin
        cnt_q <= cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_i || busy_q) begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;
endmodule

// File: rtl/num_fmt_stream.sv
// Formats one integer per request into a padded ASCII field (bin/oct/dec/hex)
// and streams it out one character per valid/ready handshake.
module num_fmt_stream
  import fmt_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_value,
  input  logic [1:0]        in_radix,
  input  logic [5:0]        in_width,
  input  logic [3:0]        in_flags,
  input  logic              in_upper,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic              out_last
);
  localparam int ND    = dec_digits(DATA_W);
  localparam int BCD_W = 4 * ND;

  state_t            state_q, st_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] val_q;
  logic [1:0]        radix_q;
  logic [5:0]        width_q;
  logic              left_q, zero_q, plus_q, neg_q, upper_q;
  logic [5:0]        pre_q, dcnt_q, post_q, ndig_q;
  logic              sgn_q;
  logic              in_ready_q, out_valid_q, out_last_q;
  logic [7:0]        out_char_q;

  logic              accept, neg_in, conv_done;
  logic [DATA_W-1:0] mag_in;
  logic [BCD_W-1:0]  bcd;
  logic [DATA_W+1:0] val_x;
  logic [3:0]        dig [DATA_W];

  assign accept = in_valid && in_ready_q;
  assign neg_in = in_flags[FLAG_SIGNED] && (in_radix == RADIX_DEC) && in_value[DATA_W-1];
  assign mag_in = neg_in ? (~in_value + 1'b1) : in_value;

  bin2bcd_dd #(.DATA_W(DATA_W), .BCD_W(BCD_W)) u_dd (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept && (in_radix == RADIX_DEC)),
    .bin_i   (mag_in),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  // Digit gi (least significant first) of the latched value in the latched radix.
  assign val_x = {2'b00, val_q};
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_dig
    logic [3:0] d_oct, d_hex, d_dec;
    if (3 * gi < DATA_W) begin : g_oct
      assign d_oct = {1'b0, val_x[3*gi +: 3]};
    end else begin : g_oct_z
      assign d_oct = 4'd0;
    end
    if (4 * gi < DATA_W) begin : g_hex
      assign d_hex = val_q[4*gi +: 4];
    end else begin : g_hex_z
      assign d_hex = 4'd0;
    end
    if (gi < ND) begin : g_dec
      assign d_dec = bcd[4*gi +: 4];
    end else begin : g_dec_z
      assign d_dec = 4'd0;
    end
    assign dig[gi] = (radix_q == RADIX_BIN) ? {3'b000, val_q[gi]} :
                     (radix_q == RADIX_OCT) ? d_oct :
                     (radix_q == RADIX_HEX) ? d_hex : d_dec;
  end

  logic       scan, sgn_s, p_sgn, last_d;
  logic [5:0] ndig_s, pre_s, zer_s, post_s, dcnt_s, pad6, idx;
  logic [5:0] p_pre, p_dcnt, p_post, p_ndig;
  logic [6:0] need, total;
  logic [3:0] dsel;
  logic [7:0] char_d;

  always_comb begin
    ndig_s = 6'd1;
    for (int i = 0; i < DATA_W; i++) begin
      if (dig[i] != 4'd0) ndig_s = 6'(i + 1);
    end
    sgn_s  = (radix_q == RADIX_DEC) && (neg_q || plus_q);
    need   = {6'd0, sgn_s} + {1'b0, ndig_s};
    total  = ({1'b0, width_q} > need) ? {1'b0, width_q} : need;
    pad6   = 6'(total - need);
    pre_s  = (!left_q && !zero_q) ? pad6 : 6'd0;
    zer_s  = (!left_q && zero_q) ? pad6 : 6'd0;
    post_s = left_q ? pad6 : 6'd0;
    dcnt_s = ndig_s + zer_s;

    // In SCAN the field layout is being computed this cycle, so use it directly.
    scan   = (state_q == S_SCAN);
    p_pre  = scan ? pre_s  : pre_q;
    p_sgn  = scan ? sgn_s  : sgn_q;
    p_dcnt = scan ? dcnt_s : dcnt_q;
    p_post = scan ? post_s : post_q;
    p_ndig = scan ? ndig_s : ndig_q;

    st_d  = S_IDLE;
    cnt_d = 6'd0;
    if (!scan && cnt_q > 6'd1) begin
      st_d  = state_q;
      cnt_d = cnt_q - 6'd1;
    end else if (scan && p_pre != 6'd0) begin
      st_d  = S_PRE_PAD;
      cnt_d = p_pre;
    end else if ((scan || state_q == S_PRE_PAD) && p_sgn) begin
      st_d  = S_SIGN;
      cnt_d = 6'd1;
    end else if (scan || state_q == S_PRE_PAD || state_q == S_SIGN) begin
      st_d  = S_DIGITS;
      cnt_d = p_dcnt;
    end else if (state_q == S_DIGITS && p_post != 6'd0) begin
      st_d  = S_POST_PAD;
      cnt_d = p_post;
    end

    idx  = cnt_d - 6'd1;
    dsel = 4'd0;
    for (int i = 0; i < DATA_W; i++) begin
      if (6'(i) == idx) dsel = dig[i];
    end

    char_d = 8'h00;
    case (st_d)
      S_PRE_PAD, S_POST_PAD: char_d = ASCII_SPACE;
      S_SIGN:   char_d = neg_q ? ASCII_MINUS : ASCII_PLUS;
      S_DIGITS: begin
        if (idx >= p_ndig)      char_d = ASCII_ZERO;
        else if (dsel < 4'd10)  char_d = ASCII_ZERO + {4'd0, dsel};
        else                    char_d = (upper_q ? ASCII_UC_A : ASCII_LC_A) + {4'd0, dsel} - 8'd10;
      end
      default: char_d = 8'h00;
    endcase

    last_d = (cnt_d == 6'd1) &&
             ((st_d == S_POST_PAD) || (st_d == S_DIGITS && p_post == 6'd0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 6'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_char_q  <= 8'h00;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            in_ready_q <= 1'b0;
            val_q      <= mag_in;
            radix_q    <= in_radix;
            width_q    <= in_width;
            left_q     <= in_flags[FLAG_LEFT];
            zero_q     <= in_flags[FLAG_ZERO];
            plus_q     <= in_flags[FLAG_PLUS];
            neg_q      <= neg_in;
            upper_q    <= in_upper;
            state_q    <= (in_radix == RADIX_DEC) ? S_CONV : S_SCAN;
          end
        end
        S_CONV: if (conv_done) state_q <= S_SCAN;
        default: begin
          if (scan || (out_valid_q && out_ready)) begin
            state_q     <= st_d;
            cnt_q       <= cnt_d;
            out_valid_q <= (st_d != S_IDLE);
            out_char_q  <= char_d;
            out_last_q  <= last_d;
            in_ready_q  <= (st_d == S_IDLE);
            if (scan) begin
              pre_q  <= pre_s;
              sgn_q  <= sgn_s;
              dcnt_q <= dcnt_s;
              post_q <= post_s;
              ndig_q <= ndig_s;
            end
          end
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign out_last  = out_last_q;
endmodule

// File: tb/tb_num_fmt_stream.sv
// Scoreboard bench for num_fmt_stream: expected characters are queued when a
// request is driven and popped as the DUT streams each character out.
module tb_num_fmt_stream;
  import fmt_pkg::*;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_value = '0;
  logic [1:0]        in_radix = 2'b00;
  logic [5:0]        in_width = 6'd0;
  logic [3:0]        in_flags = 4'd0;
  logic              in_upper = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [7:0]        out_char;
  logic              out_last;

  num_fmt_stream #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_radix  (in_radix),
    .in_width  (in_width),
    .in_flags  (in_flags),
    .in_upper  (in_upper),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         first_lat;
  logic [7:0] exp_q[$];

  function automatic string rep(input string c, input int n);
    string s = "";
    for (int i = 0; i < n; i++) s = {s, c};
    return s;
  endfunction

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic send(input logic [DATA_W-1:0] v, input logic [1:0] r, input logic [5:0] w,
                      input logic [3:0] f, input logic up, input string exp);
    int n = 0;
    push_str(exp);
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); @(negedge clk); n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    in_value = v; in_radix = r; in_width = w; in_flags = f; in_upper = up; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    in_value = $urandom; in_radix = 2'($urandom); in_width = 6'($urandom);
    in_flags = 4'($urandom); in_upper = 1'($urandom);
  endtask

  task automatic collect(input string name, input bit rnd, input int max_chars, input int budget);
    int         c = 0;
    int         got = 0;
    bit         stalled = 0;
    bit         last_e;
    logic [7:0] pc = 8'h00;
    logic [7:0] e;
    logic       pl = 1'b0;
    first_lat = -1;
    while (exp_q.size() > 0 && got < max_chars) begin
      if (c > budget) begin
        checks++; failures++;
        $display("FAIL %s_timeout: %0d chars outstanding after %0d cycles, required 0", name, exp_q.size(), c);
        break;
      end
      if (out_valid === 1'b1 && first_lat < 0) first_lat = c + 1;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_char !== pc || out_last !== pl) begin
          failures++;
          $display("FAIL %s_stall_hold: valid=%b char=%h last=%b required 1 %h %b", name, out_valid, out_char, out_last, pc, pl);
        end
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid === 1'b1 && out_ready) begin
        e = exp_q.pop_front();
        last_e = (exp_q.size() == 0);
        checks++;
        if (out_char !== e) begin
          failures++;
          $display("FAIL %s_char[%0d]: got %h required %h", name, got, out_char, e);
        end
        checks++;
        if (out_last !== last_e) begin
          failures++;
          $display("FAIL %s_last[%0d]: got %b required %b", name, got, out_last, last_e);
        end
        got++;
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      pc = out_char; pl = out_last;
      @(posedge clk); c++; @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: in_ready=%b out_valid=%b required 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic run(input string name, input logic [DATA_W-1:0] v, input logic [1:0] r,
                     input logic [5:0] w, input logic [3:0] f, input logic up, input string exp);
    send(v, r, w, f, up, exp);
    collect(name, 1'b0, 999, 200);
    check_idle(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    checks++; if (out_char !== 8'h00) begin failures++; $display("FAIL rst_out_char: got %h required 00", out_char); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last: got %b required 0", out_last); end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_dec();
    send(32'd1000, RADIX_DEC, 6'd0, 4'b0000, 1'b0, "1000");
    collect("dec1000", 1'b0, 999, 200);
    checks++;
    if (first_lat != 34) begin failures++; $display("FAIL dec_latency: got %0d required 34", first_lat); end
    check_idle("dec1000");
    run("dec_signed_w11", 32'd1000, RADIX_DEC, 6'd11, 4'b0100, 1'b0, {rep(" ", 7), "1000"});
    run("dec_neg5_zero", 32'hFFFF_FFFB, RADIX_DEC, 6'd6, 4'b0110, 1'b0, "-00005");
    run("dec_min", 32'h8000_0000, RADIX_DEC, 6'd0, 4'b0100, 1'b0, "-2147483648");
    run("dec_min_unsigned", 32'h8000_0000, RADIX_DEC, 6'd0, 4'b0000, 1'b0, "2147483648");
    run("dec_plus_right", 32'd42, RADIX_DEC, 6'd5, 4'b1000, 1'b0, "  +42");
    run("dec_plus_left", 32'd7, RADIX_DEC, 6'd4, 4'b1001, 1'b0, "+7  ");
    run("dec_left_over_zero", 32'd3, RADIX_DEC, 6'd3, 4'b0011, 1'b0, "3  ");
    run("dec_zero_val", 32'd0, RADIX_DEC, 6'd0, 4'b0100, 1'b0, "0");
  endtask

  task automatic test_radix();
    send(32'd9, RADIX_BIN, 6'd8, 4'b0010, 1'b0, "00001001");
    collect("bin9", 1'b0, 999, 200);
    checks++;
    if (first_lat != 2) begin failures++; $display("FAIL bin_latency: got %0d required 2", first_lat); end
    check_idle("bin9");
    run("hex9_left", 32'd9, RADIX_HEX, 6'd14, 4'b0001, 1'b0, {"9", rep(" ", 13)});
    run("hex_upper", 32'h3E8, RADIX_HEX, 6'd0, 4'b0000, 1'b1, "3E8");
    run("hex_lower_plus", 32'h1F, RADIX_HEX, 6'd0, 4'b1100, 1'b0, "1f");
    run("hex_full", 32'hDEAD_BEEF, RADIX_HEX, 6'd0, 4'b0000, 1'b0, "deadbeef");
    run("oct0", 32'd0, RADIX_OCT, 6'd0, 4'b0000, 1'b0, "0");
    run("oct8", 32'd8, RADIX_OCT, 6'd4, 4'b0000, 1'b0, "  10");
    run("oct_max", 32'hFFFF_FFFF, RADIX_OCT, 6'd0, 4'b0000, 1'b0, "37777777777");
  endtask

  task automatic test_stall();
    send(32'd1000, RADIX_DEC, 6'd0, 4'b0000, 1'b0, "1000");
    collect("stall1000", 1'b1, 999, 400);
    check_idle("stall1000");
    send(32'hFFFF_FFFB, RADIX_DEC, 6'd9, 4'b0110, 1'b0, "-00000005");
    collect("stall_neg", 1'b1, 999, 400);
    check_idle("stall_neg");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      logic [DATA_W-1:0] v;
      int    w;
      bit    zp;
      string s;
      v  = $urandom;
      w  = $urandom_range(0, 14);
      zp = k[0];
      s  = $sformatf("%0d", v);
      while (s.len() < w) s = {zp ? "0" : " ", s};
      send(v, RADIX_DEC, 6'(w), zp ? 4'b0010 : 4'b0000, 1'b0, s);
      collect($sformatf("b2b%0d", k), k[1], 999, 400);
    end
    check_idle("b2b");
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    send(32'd1000, RADIX_DEC, 6'd0, 4'b0000, 1'b0, "1000");
    collect("mid", 1'b0, 2, 200);
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_char !== 8'h00 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_state: valid=%b ready=%b char=%h last=%b required 0 0 00 0", out_valid, in_ready, out_char, out_last);
    end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_release_ready: got %b required 1", in_ready); end
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b0) bad++;
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL mid_no_more_chars: got %0d valid cycles required 0", bad); end
    out_ready = 1'b0;
    exp_q.delete();
    run("mid_next", 32'd1000, RADIX_DEC, 6'd6, 4'b0000, 1'b0, "  1000");
  endtask

  initial begin
    test_reset();
    test_dec();
    test_radix();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/num_fmt_stream.md
NUM_FMT_STREAM -- requirements
Module: num_fmt_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the value width; legal values are 8..32 in multiples of 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: format request present.
REQ-005 SHALL have port in_ready, output, 1 bit: block idle; a request is accepted on an edge where in_valid and in_ready are both 1.
REQ-006 SHALL have port in_value, input, DATA_W bits: the value to format.
REQ-007 SHALL have port in_radix, input, 2 bits: 00 bin, 01 oct, 10 dec, 11 hex.
REQ-008 SHALL have port in_width, input, 6 bits: field width; 0 means minimum width (like %0d).
REQ-009 SHALL have port in_flags, input, 4 bits: [0] left-justify, [1] zero-pad, [2] signed decimal, [3] force '+'; [4] does not exist, so uppercase hex is in_upper.
REQ-010 SHALL have port in_upper, input, 1 bit: emit hex digits A-F instead of a-f.
REQ-011 SHALL have port out_valid, output, 1 bit: out_char is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts out_char.
REQ-013 SHALL have port out_char, output, 8 bits: ASCII character.
REQ-014 SHALL have port out_last, output, 1 bit: out_char is the final character of the field.

Function
REQ-015 SHALL latch all in_* fields on acceptance and ignore input changes until the next acceptance.
REQ-016 SHALL convert decimal with double-dabble for DATA_W cycles (CONV), then spend one SCAN cycle; acceptance at edge k gives out_valid at k+DATA_W+2.
REQ-017 SHALL slice non-decimal digits directly and spend one SCAN cycle; acceptance at edge k gives out_valid at k+2.
REQ-018 SHALL count digits in SCAN as the significant digits only; a value of 0 yields the single digit '0'.
REQ-019 SHALL, for signed decimal, treat a value with MSB 1 as negative, use its two's-complement magnitude, and emit a '-' sign.
REQ-020 SHALL emit a '+' sign for non-negative decimal when force '+' is set; binary, octal and hex never carry a sign.
REQ-021 SHALL emit total characters = max(in_width, sign + digits).
REQ-022 SHALL order characters by mode: right-justify gives spaces, sign, digits; zero-pad gives sign, '0's, digits; left-justify gives sign, digits, trailing spaces.
REQ-023 SHALL let left-justify override zero-pad.
REQ-024 SHALL step through states IDLE -> (CONV if decimal) -> SCAN -> PRE_PAD -> SIGN -> DIGITS -> POST_PAD -> IDLE, skipping any state that has zero characters to emit.
REQ-025 SHALL advance one character per edge where out_valid and out_ready are both 1.
REQ-026 SHALL hold out_char and out_last stable while out_valid=1 and out_ready=0.
REQ-027 SHALL assert out_last with exactly one character per field.
REQ-028 SHALL assert in_ready only in IDLE; the edge that transfers the last character returns the block to IDLE, so in_ready=1 in the following cycle.
REQ-029 SHALL handle -2^(DATA_W-1) signed, giving the magnitude 2^(DATA_W-1) without overflow.

Reset
REQ-030 SHALL, while rst=1 at an edge, enter IDLE with in_ready=0, out_valid=0, out_char=8'h00 and out_last=0.
REQ-031 SHALL bring in_ready to 1 in the first cycle after rst deasserts.
REQ-032 SHALL abort any conversion or partially emitted field on reset mid-operation; no further characters of that field are emitted.

Structure
REQ-033 SHALL define in shared package fmt_pkg: the radix encoding, the flag bit indices, the state enum, and the ASCII constants (space, '0', '+', '-', 'a', 'A').
REQ-034 SHALL put the double-dabble converter in sub-module bin2bcd_dd, with start/done handshake and DATA_W-cycle latency.

Verification
REQ-035 SHALL cover: 1000, dec, width 0 -> "1000", out_last on '0', first out_valid 34 cycles after acceptance (DATA_W=32).
REQ-036 SHALL cover: 1000, dec signed, width 11 -> "       1000"; -5 signed with zero-pad, width 6 -> "-00005".
REQ-037 SHALL cover: 9, bin, width 8, zero-pad -> "00001001"; 9, hex, width 14, left -> "9" followed by 13 spaces.
REQ-038 SHALL cover: 0x3E8, hex, in_upper=1, width 0 -> "3E8"; 0, oct, width 0 -> "0"; 0x80000000 signed dec -> "-2147483648".
REQ-039 SHALL cover: out_ready toggled randomly during "1000" -> identical character sequence, out_char stable while stalled.
REQ-040 SHALL cover: rst pulsed after the 2nd character -> no further characters emitted, in_ready=1 the cycle after rst drops, and the next request formats correctly.
